// File: rtl/in_frame_pkg.sv
// Shared types and default sizes for the parallel-lane input frame transmitter.
package in_frame_pkg;

    localparam int DEF_N1  = 100;
    localparam int DEF_N2  = 6;
    localparam int DEF_GAP = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_KEEP,
        ST_GAP,
        ST_DONE
    } state_t;

    typedef logic [DEF_N2-1:0][DEF_N1-1:0] frame_t;

endpackage

// File: rtl/in_frame_tx_cnt.sv
// Loadable down-counter with hold, synchronous clear and terminal-count flag.
// Used for both the bit index and the post-Keep gap countdown.
module in_frame_tx_cnt
    import in_frame_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         Clock,
    input  logic         nReset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         tc
);

    // Clear beats load, load beats decrement; otherwise the count holds.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/in_frame_tx.sv
// Host-side transmitter: latches one N2 x N1 frame and serialises it MSB first
// onto N2 lanes, followed by a Keep strobe, a settle gap and a Done pulse.
// Every output comes straight from a flop; the FSM decides next-cycle values.
module in_frame_tx
    import in_frame_pkg::*;
#(
    parameter int N1  = DEF_N1,
    parameter int N2  = DEF_N2,
    parameter int GAP = DEF_GAP
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic                  Load,
    input  logic [N2-1:0][N1-1:0] Frame,
    input  logic                  Pause,
    input  logic                  Abort,
    output logic                  Ready,
    output logic [N2-1:0]         Out,
    output logic                  Shift,
    output logic                  Keep,
    output logic                  Busy,
    output logic                  Done
);

    localparam int CW = (N1 > 1) ? $clog2(N1) : 1;
    localparam int GW = 4;
    localparam logic [CW-1:0] BIT_LAST = CW'(N1 - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    state_t                state;
    state_t                next_state;
    logic [N2-1:0][N1-1:0] frame_reg;
    logic [CW-1:0]         bit_cnt;
    logic [CW-1:0]         bit_sel;
    logic                  bit_tc;
    logic                  gap_tc;
    logic [GW-1:0]         unused_gap_cnt;
    logic                  start;
    logic                  abort_now;
    logic                  advance;
    logic                  hold;
    logic                  ready_nxt;
    logic                  shift_nxt;
    logic                  keep_nxt;
    logic                  busy_nxt;
    logic                  done_nxt;
    logic [N2-1:0]         out_nxt;

    // A paused SHIFT cycle keeps the bit index; the bit on Out was already sent.
    assign start     = (state == ST_IDLE) && Load;
    assign abort_now = (state != ST_IDLE) && Abort;
    assign advance   = (state == ST_SHIFT) && !Abort && !Pause;
    assign hold      = (state == ST_SHIFT) && !Abort && Pause;

    in_frame_tx_cnt #(.W(CW)) u_bit_cnt (
        .Clock      (Clock),
        .nReset     (nReset),
        .clear      (abort_now),
        .load       (start),
        .load_value (BIT_LAST),
        .enable     (advance && !bit_tc),
        .count      (bit_cnt),
        .tc         (bit_tc)
    );

    in_frame_tx_cnt #(.W(GW)) u_gap_cnt (
        .Clock      (Clock),
        .nReset     (nReset),
        .clear      (abort_now),
        .load       (state == ST_KEEP),
        .load_value (GAP_LAST),
        .enable     ((state == ST_GAP) && !gap_tc),
        .count      (unused_gap_cnt),
        .tc         (gap_tc)
    );

    // Capture the frame on acceptance so the host may change Frame afterwards.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            frame_reg <= '0;
        end else if (start) begin
            frame_reg <= Frame;
        end
    end

    // State register.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; Abort outranks Pause and every normal transition.
    always_comb begin
        next_state = state;
        if (abort_now) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (Load) next_state = ST_SHIFT;
                ST_SHIFT: if (!Pause && bit_tc) next_state = ST_KEEP;
                ST_KEEP:  next_state = (GAP == 0) ? ST_DONE : ST_GAP;
                ST_GAP:   if (gap_tc) next_state = ST_DONE;
                ST_DONE:  next_state = ST_IDLE;
                default:  next_state = ST_IDLE;
            endcase
        end
    end

    // Next-cycle output values; on a new load the first bit comes from Frame.
    always_comb begin
        ready_nxt = (next_state == ST_IDLE);
        busy_nxt  = (next_state != ST_IDLE);
        keep_nxt  = (next_state == ST_KEEP);
        done_nxt  = (next_state == ST_DONE);
        shift_nxt = 1'b0;
        out_nxt   = '0;
        bit_sel   = start ? BIT_LAST : bit_cnt - CW'(1);
        if (next_state == ST_SHIFT) begin
            if (hold) begin
                out_nxt = Out;
            end else begin
                shift_nxt = 1'b1;
                for (int k = 0; k < N2; k++) begin
                    out_nxt[k] = start ? Frame[k][bit_sel] : frame_reg[k][bit_sel];
                end
            end
        end
    end

    // Output register.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            Ready <= 1'b1;
            Out   <= '0;
            Shift <= 1'b0;
            Keep  <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            Ready <= ready_nxt;
            Out   <= out_nxt;
            Shift <= shift_nxt;
            Keep  <= keep_nxt;
            Busy  <= busy_nxt;
            Done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_in_frame_tx.sv
// Scoreboarded bench for in_frame_tx: a shift-left receiver rebuilds each
// frame from Out/Shift and is compared at Keep against the issued frame.
module tb_in_frame_tx;
    import in_frame_pkg::*;

    localparam int N1  = DEF_N1;
    localparam int N2  = DEF_N2;
    localparam int GAP = DEF_GAP;

    typedef struct {
        frame_t frame;
        int     keep_cyc;
    } keep_exp_t;

    logic          Clock  = 1'b0;
    logic          nReset = 1'b0;
    logic          Load   = 1'b0;
    logic          Pause  = 1'b0;
    logic          Abort  = 1'b0;
    frame_t        Frame  = '0;
    logic          Ready;
    logic [N2-1:0] Out;
    logic          Shift;
    logic          Keep;
    logic          Busy;
    logic          Done;

    int        cyc    = 0;
    int        checks = 0;
    int        errors = 0;
    keep_exp_t keep_q[$];
    int        done_q[$];
    frame_t    rx;
    int        shifts;
    keep_exp_t mon_e;
    int        mon_d;

    in_frame_tx #(.N1(N1), .N2(N2), .GAP(GAP)) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .Load   (Load),
        .Frame  (Frame),
        .Pause  (Pause),
        .Abort  (Abort),
        .Ready  (Ready),
        .Out    (Out),
        .Shift  (Shift),
        .Keep   (Keep),
        .Busy   (Busy),
        .Done   (Done)
    );

    // Free-running clock and cycle counter.
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // Hard stop in case something never returns.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_ready"}, Ready, 1);
        checkOutput({tag, "_out"}, Out, 0);
        checkOutput({tag, "_shift"}, Shift, 0);
        checkOutput({tag, "_keep"}, Keep, 0);
        checkOutput({tag, "_busy"}, Busy, 0);
        checkOutput({tag, "_done"}, Done, 0);
    endtask

    function automatic frame_t randFrame();
        frame_t       f;
        logic [127:0] tmp;
        for (int k = 0; k < N2; k++) begin
            tmp  = {$urandom, $urandom, $urandom, $urandom};
            f[k] = tmp[N1-1:0];
        end
        return f;
    endfunction

    // Monitor: behavioural receiver clocked on Shift, checked at Keep and Done.
    always @(negedge Clock) begin
        if (nReset) begin
            if (Ready) begin
                rx     = '0;
                shifts = 0;
            end
            if (Shift) begin
                for (int k = 0; k < N2; k++) rx[k] = {rx[k][N1-2:0], Out[k]};
                shifts++;
            end
            if (Keep) begin
                checkOutput("keep_pending", keep_q.size() > 0, 1);
                if (keep_q.size() > 0) begin
                    mon_e = keep_q.pop_front();
                    checkOutput("keep_cycle", cyc, mon_e.keep_cyc);
                    checkOutput("shift_count", shifts, N1);
                    for (int k = 0; k < N2; k++) checkOutput("rx_lane", rx[k], mon_e.frame[k]);
                end
            end
            if (Done) begin
                checkOutput("done_pending", done_q.size() > 0, 1);
                if (done_q.size() > 0) begin
                    mon_d = done_q.pop_front();
                    checkOutput("done_cycle", cyc, mon_d);
                end
            end
        end
    end

    // One transfer: optional pause window, abort, mid-transfer load, or
    // Load+Abort at acceptance. Offsets count cycles from the first Shift cycle.
    task automatic applyStimulus(input frame_t f, input int pstart, input int plen,
                                 input int abort_off, input int intr_off,
                                 input frame_t f2, input logic abort_at_load);
        int            first;
        int            keep_c;
        int            done_c;
        logic          aborted;
        logic [N2-1:0] last_out;
        @(negedge Clock);
        checkOutput("ready_before_load", Ready, 1);
        Load   = 1'b1;
        Frame  = f;
        Abort  = abort_at_load;
        first  = cyc + 1;
        keep_c = first + N1 + plen;
        done_c = keep_c + 1 + GAP;
        keep_q.push_back('{frame: f, keep_cyc: keep_c});
        done_q.push_back(done_c);
        aborted  = 1'b0;
        last_out = '0;
        for (int off = 0; off <= done_c - first; off++) begin
            @(negedge Clock);
            if (off == 0) begin
                checkOutput("busy_after_load", Busy, 1);
                checkOutput("ready_after_load", Ready, 0);
            end
            if (off > 0 && (off - 1) >= pstart && (off - 1) < pstart + plen) begin
                checkOutput("pause_shift_low", Shift, 0);
                checkOutput("pause_out_hold", Out, last_out);
            end
            last_out = Out;
            Load  = (off == intr_off);
            Frame = (off == intr_off) ? f2 : f;
            Pause = (off >= pstart) && (off < pstart + plen);
            Abort = (off == abort_off);
            if (Abort) begin
                if (cyc < keep_c) begin
                    void'(keep_q.pop_back());
                    void'(done_q.pop_back());
                end else if (cyc < done_c) begin
                    void'(done_q.pop_back());
                end
                aborted = 1'b1;
                @(negedge Clock);
                Load  = 1'b0;
                Pause = 1'b0;
                Abort = 1'b0;
                checkOutput("ready_after_abort", Ready, 1);
                checkOutput("busy_after_abort", Busy, 0);
                checkOutput("shift_after_abort", Shift, 0);
                checkOutput("keep_after_abort", Keep, 0);
                checkOutput("done_after_abort", Done, 0);
                break;
            end
        end
        if (!aborted) begin
            @(negedge Clock);
            Load  = 1'b0;
            Pause = 1'b0;
            checkOutput("ready_after_done", Ready, 1);
            checkOutput("busy_after_done", Busy, 0);
        end
    endtask

    // Asynchronous reset at the 30th Shift cycle of a transfer.
    task automatic resetMidTransfer(input frame_t f);
        @(negedge Clock);
        Load  = 1'b1;
        Frame = f;
        repeat (30) begin
            @(negedge Clock);
            Load = 1'b0;
        end
        checkOutput("shift_before_reset", Shift, 1);
        #2;
        nReset = 1'b0;
        #1;
        checkReset("async_reset");
        @(negedge Clock);
        nReset = 1'b1;
        repeat (3) begin
            @(negedge Clock);
            checkOutput("ready_after_reset", Ready, 1);
            checkOutput("done_after_reset", Done, 0);
        end
    endtask

    // Main stimulus sequence.
    initial begin
        frame_t f;
        int     plen;
        int     pstart;
        int     aoff;
        int     ioff;
        repeat (2) @(negedge Clock);
        checkReset("in_reset");
        nReset = 1'b1;
        @(negedge Clock);
        checkReset("after_reset");

        $display("[TB] single bit on lane 0");
        f = '0;
        f[0][0] = 1'b1;
        applyStimulus(f, 0, 0, -1, -1, '0, 1'b0);

        $display("[TB] pause 5 cycles at shift cycle 40");
        applyStimulus(randFrame(), 39, 5, -1, -1, '0, 1'b0);

        $display("[TB] abort at shift cycle 50, then full transfer");
        applyStimulus(randFrame(), 0, 0, 49, -1, '0, 1'b0);
        applyStimulus(randFrame(), 0, 0, -1, -1, '0, 1'b0);

        $display("[TB] load while busy is ignored");
        applyStimulus(randFrame(), 0, 0, -1, 9, randFrame(), 1'b0);

        $display("[TB] load and abort together in idle");
        applyStimulus(randFrame(), 0, 0, -1, -1, '0, 1'b1);

        $display("[TB] abort during pause, during keep, during gap");
        applyStimulus(randFrame(), 20, 6, 22, -1, '0, 1'b0);
        applyStimulus(randFrame(), 0, 0, N1, -1, '0, 1'b0);
        applyStimulus(randFrame(), 0, 0, N1 + 1, -1, '0, 1'b0);

        $display("[TB] reset mid-transfer");
        resetMidTransfer(randFrame());
        applyStimulus(randFrame(), 0, 0, -1, -1, '0, 1'b0);

        $display("[TB] random transfers");
        for (int i = 0; i < 8; i++) begin
            plen   = ($urandom_range(1, 0) == 1) ? $urandom_range(8, 1) : 0;
            pstart = $urandom_range(N1 - 1, 0);
            aoff   = ($urandom_range(3, 0) == 0) ? $urandom_range(N1 + plen + 1 + GAP, 0) : -1;
            ioff   = ($urandom_range(3, 0) == 0) ? $urandom_range(N1 - 1, 0) : -1;
            applyStimulus(randFrame(), pstart, plen, aoff, ioff, randFrame(),
                          1'($urandom_range(1, 0)));
        end

        repeat (2) @(negedge Clock);
        checkOutput("keep_queue_empty", keep_q.size(), 0);
        checkOutput("done_queue_empty", done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
